// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scancodes, held-map bit positions and receiver states.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // held is packed {up, down, left, right}
  localparam int HELD_UP    = 3;
  localparam int HELD_DOWN  = 2;
  localparam int HELD_LEFT  = 1;
  localparam int HELD_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the raw lines, samples on falling ps2_clk,
// checks odd parity and stop bit, and aborts stalled frames after a timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYC);

  logic [2:0]    clk_sync_d, clk_sync_q;
  logic [1:0]    data_sync_d, data_sync_q;
  rx_state_e     state_d, state_q;
  logic [2:0]    bit_cnt_d, bit_cnt_q;
  logic [7:0]    shift_d, shift_q;
  logic [TW-1:0] to_cnt_d, to_cnt_q;
  logic          byte_valid_d, byte_valid_q;
  logic          rx_err_d, rx_err_q;
  logic          fall;
  logic          data_s;

  // Bit 2 of the clock chain is the previous synchronized sample, used only for edge detect.
  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_s = data_sync_q[1];

  always_comb begin
    clk_sync_d   = {clk_sync_q[1:0], ps2_clk};
    data_sync_d  = {data_sync_q[0], ps2_data};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    rx_err_d     = 1'b0;

    if (state_q == IDLE || fall) to_cnt_d = '0;
    else                         to_cnt_d = to_cnt_q + 1'b1;

    if (state_q != IDLE && to_cnt_q == TO_LIMIT) begin
      rx_err_d = 1'b1;
      state_d  = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          if (^{shift_q, data_s}) begin
            state_d = STOP;
          end else begin
            rx_err_d = 1'b1;
            state_d  = IDLE;
          end
        end
        STOP: begin
          if (data_s) byte_valid_d = 1'b1;
          else        rx_err_d     = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q   <= 3'b111;
      data_sync_q  <= 2'b11;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      rx_err_q     <= rx_err_d;
    end
  end

  // Payload shift register carries data only; framing validity comes from byte_valid.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_byte    = shift_q;
  assign byte_valid = byte_valid_q;
  assign rx_err     = rx_err_q;

endmodule

// File: rtl/ps2_sprite_ctrl.sv
// Keyboard-driven sprite motion: decodes E0/F0 arrow-key sequences into a held map
// and steps the sprite centre once per video frame, clamped to the visible area.
module ps2_sprite_ctrl
  import ps2_pkg::*;
#(
  parameter int H_PIXELS    = 640,
  parameter int V_PIXELS    = 480,
  parameter int SQUARE_SIZE = 10,
  parameter int INIT_X      = 320,
  parameter int INIT_Y      = 240,
  parameter int STEP        = 1,
  parameter int TIMEOUT_CYC = 2500
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       frame_tick,
  output logic [9:0] sq_pos_x,
  output logic [9:0] sq_pos_y,
  output logic [3:0] held,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       rx_err
);

  localparam logic [10:0] LO     = 11'(SQUARE_SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  STEP10 = 10'(STEP);
  localparam logic [9:0]  X_HI   = 10'(H_PIXELS - 1 - SQUARE_SIZE);
  localparam logic [9:0]  Y_HI   = 10'(V_PIXELS - 1 - SQUARE_SIZE);

  // One axis step; sums are 11 bits wide so neither end can wrap.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic dec,
                                           input logic inc, input logic [9:0] hi);
    logic [10:0] up_sum;
    logic [9:0]  r;
    up_sum = {1'b0, pos} + STEP11;
    r      = pos;
    if (dec && !inc) begin
      if ({1'b0, pos} >= LO + STEP11) r = pos - STEP10;
      else                            r = LO[9:0];
    end else if (inc && !dec) begin
      if (up_sum <= {1'b0, hi}) r = pos + STEP10;
      else                      r = hi;
    end
    return r;
  endfunction

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       rx_err_w;

  ps2_rx_frame #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk       (vga_clk),
    .rst       (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .rx_err    (rx_err_w)
  );

  logic       ext_d, ext_q, brk_d, brk_q;
  logic [3:0] held_d, held_q;
  logic       key_valid_d, key_valid_q;
  logic [7:0] key_code_d, key_code_q;
  logic       key_ext_d, key_ext_q, key_break_d, key_break_q;
  logic [9:0] pos_x_d, pos_x_q, pos_y_d, pos_y_q;

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    held_d      = held_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;

    if (rx_err_w) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        key_valid_d = 1'b1;
        key_code_d  = rx_byte;
        key_ext_d   = ext_q;
        key_break_d = brk_q;
        ext_d       = 1'b0;
        brk_d       = 1'b0;
        if (ext_q) begin
          unique case (rx_byte)
            SC_UP:    held_d[HELD_UP]    = !brk_q;
            SC_DOWN:  held_d[HELD_DOWN]  = !brk_q;
            SC_LEFT:  held_d[HELD_LEFT]  = !brk_q;
            SC_RIGHT: held_d[HELD_RIGHT] = !brk_q;
            default:  held_d = held_q;
          endcase
        end
      end
    end
  end

  // Motion reads held_q, so a key decoded in the same cycle only counts next frame.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (frame_tick) begin
      pos_x_d = step_axis(pos_x_q, held_q[HELD_LEFT], held_q[HELD_RIGHT], X_HI);
      pos_y_d = step_axis(pos_y_q, held_q[HELD_UP], held_q[HELD_DOWN], Y_HI);
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      pos_x_q     <= 10'(INIT_X);
      pos_y_q     <= 10'(INIT_Y);
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      held_q      <= held_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
    end
  end

  assign sq_pos_x  = pos_x_q;
  assign sq_pos_y  = pos_y_q;
  assign held      = held_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign rx_err    = rx_err_w;

endmodule

// File: doc/ps2_sprite_ctrl.md
Name: ps2_sprite_ctrl

Overview:
Keyboard-driven motion controller for the VGA sprite. It receives PS/2 frames, validates them, and decodes E0/F0 make/break sequences into a held-key state for the four arrow keys. Once per video frame it steps the sprite centre position, clamped to the visible area. It sits in the vga_clk (25 MHz) domain beside the VGA timing generator and feeds that generator sq_pos_x and sq_pos_y.

Parameters:
H_PIXELS, 640, visible width
V_PIXELS, 480, visible height
SQUARE_SIZE, 10, sprite half-size; sets the clamp margin
INIT_X, 320, centre X after reset
INIT_Y, 240, centre Y after reset
STEP, 1, pixels moved per frame per axis
TIMEOUT_CYC, 2500, vga_clk cycles without a PS/2 falling edge before a partial frame is aborted (100 us)

Ports:
vga_clk  in  1  25 MHz pixel clock; the only clock
reset  in  1  asynchronous, active-high
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
frame_tick  in  1  one-cycle pulse per video frame from the VGA timing generator
sq_pos_x  out  10  sprite centre X
sq_pos_y  out  10  sprite centre Y
held  out  4  {up,down,left,right} arrow-held flags
key_valid  out  1  one-cycle pulse: complete key event decoded
key_code  out  8  scancode of the last event
key_ext  out  1  last event was E0-prefixed
key_break  out  1  last event was a release (F0-prefixed)
rx_err  out  1  one-cycle pulse on parity, stop or timeout error

Behaviour:
- Reset values: sq_pos_x=INIT_X, sq_pos_y=INIT_Y, held=0, key_valid=0, key_code=0, key_ext=0, key_break=0, rx_err=0. All FSMs go to IDLE. Reset asserted mid-frame discards any partial byte and all prefix flags.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchronizer. A falling edge is detected from the synchronized ps2_clk; every bit is sampled on that edge.
- Receiver FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: a sampled 0 moves to DATA; a sampled 1 is ignored.
  - DATA: 8 bits, LSB first.
  - PARITY: data plus parity bit must have odd parity.
  - STOP: the sampled bit must be 1.
  - Good frame: byte_valid pulses the cycle after the stop-bit edge.
  - Bad parity or bad stop: rx_err pulses, byte is discarded, FSM returns to IDLE.
- Timeout: a counter clears on every falling edge and while in IDLE. Outside IDLE, reaching TIMEOUT_CYC aborts the frame: rx_err pulses, FSM returns to IDLE.
- Decoder, on byte_valid:
  - 0xE0: set ext.
  - 0xF0: set brk.
  - Any other byte: pulse key_valid and latch key_code, key_ext=ext, key_break=brk in the same cycle; then clear ext and brk.
  - rx_err clears ext and brk.
- Held map, updated only when ext=1: 0x75 up, 0x72 down, 0x6B left, 0x74 right. Make sets the bit, break clears it. Non-extended codes (including 0xAA, 0xFA) are reported on key_* but never change held.
- Motion on frame_tick, using held as registered before any same-cycle decoder update:
  - Y: up&!down gives y-STEP when y >= SQUARE_SIZE+STEP, else y=SQUARE_SIZE. down&!up gives y+STEP when y+STEP <= V_PIXELS-1-SQUARE_SIZE, else y=V_PIXELS-1-SQUARE_SIZE.
  - X: same rule with left/right and H_PIXELS.
  - Both opposite keys held, or neither: that axis holds.
  - No bounce; position clamps at the limit.
  - The new position appears on the outputs the cycle after frame_tick.
- Arithmetic: 11-bit internal sums, so no wrap at 0 or 1023.

Decomposition:
- Shared package ps2_pkg:
  - scancode constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_UP=8'h75, SC_DOWN=8'h72, SC_LEFT=8'h6B, SC_RIGHT=8'h74
  - held-bit index constants
  - receiver state enum
- One sub-module, ps2_rx_frame: synchronizer, edge detect, receiver FSM and timeout; outputs byte, byte_valid, rx_err.

Test Plan:
- Frames E0,75 -> key_valid with code 0x75, ext=1, break=0; held=4'b1000; after 3 frame_ticks sq_pos_y=237, sq_pos_x=320.
- Frames E0,F0,75 after the above -> key_break=1, held=0; further frame_ticks leave sq_pos_y=237.
- Hold right from x=628 (limit 629) for 5 ticks -> x=629 and stays; hold left from x=10 -> stays 10.
- Frame 0x1C with wrong parity -> rx_err pulse, no key_valid, held unchanged. Stop bit 0 -> same result.
- Send 5 bits then idle 2500 cycles -> rx_err pulse. Next good frame E0,6B -> held[left]=1.
- Up and down both held, then reset asserted mid-frame -> y unchanged while both held; after reset x=320, y=240, held=0, no stale prefix carried into the next byte.
